regfile_wb_sched: RTL

//  Write-back scheduler for the regfile block: shares one regfile write port between the

---
 rtl/regfile_wb_sched.sv | 96 +++++++++
 1 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: one regfile write port shared by a fixed-priority primary
// and round-robin secondaries, with a wait counter that throttles the primary.
module regfile_wb_sched #(
    parameter int width_p           = 32,
    parameter int els_p             = 32,
    parameter int num_req_p         = 3,
    parameter int max_wait_p        = 8,
    parameter bit x0_tied_to_zero_p = 1'b1,
    localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    pri_v_i,
    input  logic [addr_width_lp-1:0]                pri_addr_i,
    input  logic [width_p-1:0]                      pri_data_i,
    output logic                                    pri_ready_o,
    input  logic [num_req_p-1:0]                    req_v_i,
    input  logic [num_req_p-1:0][addr_width_lp-1:0] req_addr_i,
    input  logic [num_req_p-1:0][width_p-1:0]       req_data_i,
    output logic [num_req_p-1:0]                    req_yumi_o,
    output logic                                    w_v_o,
    output logic [addr_width_lp-1:0]                w_addr_o,
    output logic [width_p-1:0]                      w_data_o
);
    localparam int ptr_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cnt_w = (max_wait_p > 1) ? $clog2(max_wait_p + 1) : 1;

    logic [ptr_w-1:0]         rr_ptr;
    logic [cnt_w-1:0]         wait_cnt;
    logic                     throttle_r;

    logic                     sec_found;
    logic [ptr_w-1:0]         sec_idx;
    logic [ptr_w:0]           cand;
    logic                     pri_gnt, sec_gnt, blocked, drop;
    logic [addr_width_lp-1:0] gnt_addr;
    logic [width_p-1:0]       gnt_data;

    // Rotating search starting at rr_ptr; the extra bit on cand covers the wrap.
    always_comb begin
        sec_found = 1'b0;
        sec_idx   = '0;
        cand      = '0;
        for (int i = 0; i < num_req_p; i++) begin
            cand = {1'b0, rr_ptr} + (ptr_w+1)'(i);
            if (cand >= (ptr_w+1)'(num_req_p))
                cand = cand - (ptr_w+1)'(num_req_p);
            if (!sec_found && req_v_i[cand[ptr_w-1:0]]) begin
                sec_found = 1'b1;
                sec_idx   = cand[ptr_w-1:0];
            end
        end
    end

    assign pri_ready_o = ~throttle_r & ~reset_i;
    assign pri_gnt     = pri_v_i & pri_ready_o;
    assign sec_gnt     = ~pri_gnt & sec_found & ~reset_i;
    assign req_yumi_o  = sec_gnt ? (num_req_p'(1) << sec_idx) : '0;
    assign blocked     = (|req_v_i) & ~sec_gnt;
    assign gnt_addr    = pri_gnt ? pri_addr_i : req_addr_i[sec_idx];
    assign gnt_data    = pri_gnt ? pri_data_i : req_data_i[sec_idx];
    // x0 writes complete the handshake but never reach the regfile.
    assign drop        = x0_tied_to_zero_p && (gnt_addr == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            w_v_o      <= 1'b0;
            w_addr_o   <= '0;
            w_data_o   <= '0;
            rr_ptr     <= '0;
            wait_cnt   <= '0;
            throttle_r <= 1'b0;
        end else begin
            if (pri_gnt || sec_gnt) begin
                w_v_o    <= ~drop;
                w_addr_o <= gnt_addr;
                w_data_o <= gnt_data;
            end else begin
                w_v_o <= 1'b0;
            end

            if (sec_gnt)
                rr_ptr <= (sec_idx == ptr_w'(num_req_p - 1)) ? '0 : sec_idx + ptr_w'(1);

            if (blocked) begin
                if (wait_cnt != cnt_w'(max_wait_p))
                    wait_cnt <= wait_cnt + cnt_w'(1);
                if (wait_cnt == cnt_w'(max_wait_p - 1))
                    throttle_r <= 1'b1;
            end else begin
                wait_cnt   <= '0;
                throttle_r <= 1'b0;
            end
        end
    end
endmodule
